// File: rtl/vec_pkg.sv
// Shared definitions for the PCPI vector dispatcher.
//   OPCODE_CUSTOM0      major opcode claimed by the dispatcher (custom-0)
//   VEC_TIMEOUT_DEFAULT default watchdog limit, in BUSY cycles
//   F3_*                funct3 codes understood by the vector unit
//   disp_state_e        dispatcher FSM states
package vec_pkg;

  localparam logic [6:0] OPCODE_CUSTOM0      = 7'b0001011;
  localparam int         VEC_TIMEOUT_DEFAULT = 1024;

  localparam logic [2:0] F3_VADD  = 3'b000;
  localparam logic [2:0] F3_VSUB  = 3'b001;
  localparam logic [2:0] F3_VMUL  = 3'b010;
  localparam logic [2:0] F3_VMAC  = 3'b011;
  localparam logic [2:0] F3_VLOGIC = 3'b100;
  localparam logic [2:0] F3_VSHIFT = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_BUSY  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } disp_state_e;

endpackage

// File: rtl/pcpi_vector_dispatch.sv
// Dispatcher between the picorv32 PCPI port and the vector processing unit.
// Claims custom-0 instructions, issues a one-cycle start to the vector unit,
// waits for vec_done under a watchdog and answers through pcpi_ready.
// Unclaimed opcodes leave every output untouched so the core traps.
//
// Ports
//   clk, resetn                     clock, async active-low reset
//   pcpi_valid/insn/rs1/rs2         instruction presented by the core
//   pcpi_wr/rd/wait/ready           response to the core (all registered)
//   vec_start/funct/op_a/op_b       issue to the vector unit
//   vec_abort                       one-cycle cancel to the vector unit
//   vec_done/vec_result             completion from the vector unit
//   timeout_err                     sticky watchdog-expiry flag
//   op_count                        completed-instruction counter (wraps)
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for a claimable instruction
// ST_ISSUE | vec_start pulse high, watchdog cleared
// ST_BUSY  | waiting for vec_done, watchdog running
// ST_RESP  | pcpi_ready pulse high with result
// ST_DRAIN | wait for the core to drop pcpi_valid before re-arming
module pcpi_vector_dispatch
  import vec_pkg::*;
#(
  parameter logic [6:0] OPCODE         = OPCODE_CUSTOM0,
  parameter int         TIMEOUT_CYCLES = VEC_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        vec_start,
  output logic [9:0]  vec_funct,
  output logic [31:0] vec_op_a,
  output logic [31:0] vec_op_b,
  output logic        vec_abort,
  input  logic        vec_done,
  input  logic [31:0] vec_result,
  output logic        timeout_err,
  output logic [15:0] op_count
);

  localparam int             WDW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT_CYCLES - 1);

  disp_state_e    state_q;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic [15:0]    op_count_q, op_count_d;
  logic           rd_nz_q;
  logic           pcpi_wr_q, pcpi_wait_q, pcpi_ready_q;
  logic [31:0]    pcpi_rd_q;
  logic           vec_start_q, vec_abort_q, timeout_err_q;
  logic [9:0]     vec_funct_q;
  logic [31:0]    vec_op_a_q, vec_op_b_q;
  logic           claim;
  logic           unused_insn_bits;

  assign claim      = pcpi_valid && (pcpi_insn[6:0] == OPCODE);
  // Saturating: the FSM leaves BUSY at WDOG_LAST, so the hold is only a guard.
  assign wdog_d     = (wdog_q == WDOG_LAST) ? wdog_q : wdog_q + WDW'(1);
  assign op_count_d = op_count_q + 16'd1;
  // Register-number fields of the source operands are resolved by the core.
  assign unused_insn_bits = ^pcpi_insn[24:15];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      wdog_q        <= '0;
      op_count_q    <= '0;
      rd_nz_q       <= 1'b0;
      pcpi_wr_q     <= 1'b0;
      pcpi_rd_q     <= '0;
      pcpi_wait_q   <= 1'b0;
      pcpi_ready_q  <= 1'b0;
      vec_start_q   <= 1'b0;
      vec_abort_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      vec_funct_q   <= '0;
      vec_op_a_q    <= '0;
      vec_op_b_q    <= '0;
    end else begin
      vec_start_q  <= 1'b0;
      vec_abort_q  <= 1'b0;
      pcpi_ready_q <= 1'b0;
      pcpi_wr_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (claim) begin
            vec_op_a_q  <= pcpi_rs1;
            vec_op_b_q  <= pcpi_rs2;
            vec_funct_q <= {pcpi_insn[31:25], pcpi_insn[14:12]};
            rd_nz_q     <= (pcpi_insn[11:7] != 5'd0);
            vec_start_q <= 1'b1;
            pcpi_wait_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wdog_q  <= '0;
          state_q <= ST_BUSY;
        end
        ST_BUSY: begin
          if (!pcpi_valid) begin
            // Core withdrew the instruction: cancel silently, nothing retires.
            vec_abort_q <= 1'b1;
            pcpi_wait_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (vec_done) begin
            // Checked before expiry so a same-cycle done still returns data.
            pcpi_rd_q    <= vec_result;
            pcpi_wr_q    <= rd_nz_q;
            pcpi_ready_q <= 1'b1;
            pcpi_wait_q  <= 1'b0;
            op_count_q   <= op_count_d;
            state_q      <= ST_RESP;
          end else if (wdog_q == WDOG_LAST) begin
            pcpi_rd_q     <= '0;
            pcpi_wr_q     <= rd_nz_q;
            pcpi_ready_q  <= 1'b1;
            pcpi_wait_q   <= 1'b0;
            vec_abort_q   <= 1'b1;
            timeout_err_q <= 1'b1;
            op_count_q    <= op_count_d;
            state_q       <= ST_RESP;
          end else begin
            wdog_q <= wdog_d;
          end
        end
        ST_RESP: begin
          state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!pcpi_valid) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pcpi_wr     = pcpi_wr_q;
  assign pcpi_rd     = pcpi_rd_q;
  assign pcpi_wait   = pcpi_wait_q;
  assign pcpi_ready  = pcpi_ready_q;
  assign vec_start   = vec_start_q;
  assign vec_funct   = vec_funct_q;
  assign vec_op_a    = vec_op_a_q;
  assign vec_op_b    = vec_op_b_q;
  assign vec_abort   = vec_abort_q;
  assign timeout_err = timeout_err_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_pcpi_vector_dispatch.sv
// Self-checking bench for pcpi_vector_dispatch (watchdog limit 8).
// Table of single-instruction transactions plus hand-written sequences for
// foreign opcodes, core withdrawal during BUSY and reset during BUSY.
module tb_pcpi_vector_dispatch;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = '0;
  logic [31:0] pcpi_rs1 = '0;
  logic [31:0] pcpi_rs2 = '0;
  logic        vec_done = 1'b0;
  logic [31:0] vec_result = '0;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
  logic        vec_start, vec_abort, timeout_err;
  logic [9:0]  vec_funct;
  logic [31:0] vec_op_a, vec_op_b;
  logic [15:0] op_count;

  pcpi_vector_dispatch #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready),
    .vec_start  (vec_start),
    .vec_funct  (vec_funct),
    .vec_op_a   (vec_op_a),
    .vec_op_b   (vec_op_b),
    .vec_abort  (vec_abort),
    .vec_done   (vec_done),
    .vec_result (vec_result),
    .timeout_err(timeout_err),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // dly: cycles from the vec_start cycle to the vec_done cycle, -1 = never.
  // lat: cycle (counted from the cycle the instruction is presented) at which
  // pcpi_ready is seen.
  typedef struct {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          dly;
    logic [31:0] res;
    int          lat;
    logic        wr;
    logic [31:0] rd;
    int          aborts;
    logic        terr;
    logic [15:0] cnt;
    logic [9:0]  funct;
  } vec_t;

  vec_t tv[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int          k = 0;
    int          start_k = -1;
    int          ready_k = -1;
    int          starts = 0;
    int          readys = 0;
    int          aborts = 0;
    logic        wr_s = 1'b0;
    logic [31:0] rd_s = '0;
    logic        terr_s = 1'b0;
    logic [15:0] cnt_s = '0;
    pcpi_valid = 1'b1;
    pcpi_insn  = v.insn;
    pcpi_rs1   = v.rs1;
    pcpi_rs2   = v.rs2;
    while (ready_k < 0 && k < 40) begin
      step();
      k++;
      vec_done = 1'b0;
      if (vec_start) begin
        starts++;
        start_k = k;
        chk({tag, " funct"}, 32'(vec_funct), 32'(v.funct));
        chk({tag, " op_a"}, vec_op_a, v.rs1);
        chk({tag, " op_b"}, vec_op_b, v.rs2);
        chk({tag, " wait_at_start"}, 32'(pcpi_wait), 32'd1);
      end
      if (vec_abort) aborts++;
      if (pcpi_ready) begin
        ready_k = k;
        readys++;
        wr_s    = pcpi_wr;
        rd_s    = pcpi_rd;
        terr_s  = timeout_err;
        cnt_s   = op_count;
        chk({tag, " wait_at_ready"}, 32'(pcpi_wait), 32'd0);
      end else if (v.dly >= 0 && start_k >= 0 && k == start_k + v.dly) begin
        vec_done   = 1'b1;
        vec_result = v.res;
      end
    end
    vec_done   = 1'b0;
    pcpi_valid = 1'b0;
    if (ready_k < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s ready_timeout: got no pcpi_ready in 40 cycles, expected one", tag);
    end
    repeat (3) begin
      step();
      if (pcpi_ready) readys++;
      if (vec_start)  starts++;
      if (vec_abort)  aborts++;
    end
    chk({tag, " latency"}, 32'(ready_k), 32'(v.lat));
    chk({tag, " starts"}, 32'(starts), 32'd1);
    chk({tag, " readys"}, 32'(readys), 32'd1);
    chk({tag, " aborts"}, 32'(aborts), 32'(v.aborts));
    chk({tag, " pcpi_wr"}, 32'(wr_s), 32'(v.wr));
    chk({tag, " pcpi_rd"}, rd_s, v.rd);
    chk({tag, " timeout_err"}, 32'(terr_s), 32'(v.terr));
    chk({tag, " op_count"}, 32'(cnt_s), 32'(v.cnt));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " flags"}, 32'({pcpi_wr, pcpi_wait, pcpi_ready, vec_start, vec_abort, timeout_err}), 32'd0);
    chk({tag, " pcpi_rd"}, pcpi_rd, 32'd0);
    chk({tag, " op_a"}, vec_op_a, 32'd0);
    chk({tag, " op_b"}, vec_op_b, 32'd0);
    chk({tag, " funct"}, 32'(vec_funct), 32'd0);
    chk({tag, " op_count"}, 32'(op_count), 32'd0);
  endtask

  initial begin
    int          hi_wait, hi_ready, hi_start, n_abort, n_ready;
    logic [15:0] cnt_before;
    logic [31:0] rd_before;
    vec_t        after_rst;

    //        insn          rs1           rs2           dly res           lat wr    rd            ab terr  cnt     funct
    tv[0] = '{32'h0000050B, 32'd5,        32'd7,        2,  32'd12,       4,  1'b1, 32'd12,       0, 1'b0, 16'd1, 10'h000};
    tv[1] = '{32'h0000000B, 32'd1,        32'd2,        2,  32'd99,       4,  1'b0, 32'd99,       0, 1'b0, 16'd2, 10'h000};
    tv[2] = '{32'h2A00518B, 32'h1234,     32'hABCD,     1,  32'hDEADBEEF, 3,  1'b1, 32'hDEADBEEF, 0, 1'b0, 16'd3, 10'h0AD};
    tv[3] = '{32'h0000050B, 32'd0,        32'd0,        8,  32'h55,       10, 1'b1, 32'h55,       0, 1'b0, 16'd4, 10'h000};
    tv[4] = '{32'h0000050B, 32'd3,        32'd4,        -1, 32'h0,        10, 1'b1, 32'h0,        1, 1'b1, 16'd5, 10'h000};
    tv[5] = '{32'h0000050B, 32'hFFFFFFFF, 32'h1,        3,  32'd7,        5,  1'b1, 32'd7,        0, 1'b1, 16'd6, 10'h000};

    #2;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_op(tv[i], $sformatf("vec%0d", i));

    // Foreign opcode held for 20 cycles: nothing may move.
    cnt_before = op_count;
    rd_before  = pcpi_rd;
    hi_wait = 0; hi_ready = 0; hi_start = 0;
    pcpi_valid = 1'b1;
    pcpi_insn  = 32'h00000533;
    repeat (20) begin
      step();
      if (pcpi_wait)  hi_wait++;
      if (pcpi_ready) hi_ready++;
      if (vec_start)  hi_start++;
    end
    pcpi_valid = 1'b0;
    chk("foreign wait", 32'(hi_wait), 32'd0);
    chk("foreign ready", 32'(hi_ready), 32'd0);
    chk("foreign start", 32'(hi_start), 32'd0);
    chk("foreign op_count", 32'(op_count), 32'(cnt_before));
    chk("foreign pcpi_rd", pcpi_rd, rd_before);

    // Core drops pcpi_valid while BUSY: abort, no response, no count.
    step();
    n_abort = 0; n_ready = 0;
    pcpi_valid = 1'b1;
    pcpi_insn  = 32'h0000050B;
    step();
    chk("withdraw start", 32'(vec_start), 32'd1);
    step();
    pcpi_valid = 1'b0;
    repeat (5) begin
      step();
      if (vec_abort)  n_abort++;
      if (pcpi_ready) n_ready++;
    end
    chk("withdraw aborts", 32'(n_abort), 32'd1);
    chk("withdraw readys", 32'(n_ready), 32'd0);
    chk("withdraw op_count", 32'(op_count), 32'd6);
    chk("withdraw wait", 32'(pcpi_wait), 32'd0);

    // Reset in the middle of BUSY with pcpi_valid held across it.
    pcpi_valid = 1'b1;
    pcpi_insn  = 32'h0000050B;
    pcpi_rs1   = 32'h11;
    pcpi_rs2   = 32'h22;
    repeat (3) step();
    chk("pre_reset wait", 32'(pcpi_wait), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk);
    #1 resetn = 1'b1;
    after_rst = '{32'h0000050B, 32'h11, 32'h22, 1, 32'h77, 3, 1'b1, 32'h77, 0, 1'b0, 16'd1, 10'h000};
    run_op(after_rst, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
